uart_frame_rx: RTL

- Downstream consumer of the UART receive FIFO.
- Pops bytes via the FIFO read strobe, hunts for a start-of-frame byte, then parses length, payload and checksum.
- Buffers the payload and releases it as a valid/ready byte stream with a last flag, but only after the checksum passes.
- Malformed, corrupted or stalled frames are dropped and flagged with one-cycle error pulses.

---
 rtl/uart_frame_pkg.sv | 17 +
 rtl/uart_frame_buf.sv | 36 +++
 rtl/uart_frame_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
// Shared definitions for the UART frame receiver:
//   state_t      - frame parser states
//   SOF_DEFAULT  - default start-of-frame byte value
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        SEND
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf
// DEPTH x 8 payload register file: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
// Ports:
//   clk    in  system clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational from raddr)
module uart_frame_buf #(
    parameter int  DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // One write-enable decode per entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_ff @(posedge clk) begin
            if (we && (waddr == AW'(gi))) begin
                mem[gi] <= wdata;
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
// Pops bytes from a UART RX FIFO, hunts for SOF, parses LEN / payload /
// XOR checksum, buffers the payload and, only if the checksum matches,
// releases it as a valid/ready byte stream with a last flag.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-low reset
//   rx_empty   in  RX FIFO empty flag
//   r_data     in  RX FIFO head byte
//   rd_uart    out RX FIFO pop strobe (combinational)
//   m_data     out payload byte
//   m_valid    out m_data valid
//   m_ready    in  downstream accepts byte
//   m_last     out final payload byte of the frame
//   frame_len  out length of the frame being output
//   err_len    out one-cycle pulse: LEN byte zero or above MAX_LEN
//   err_chk    out one-cycle pulse: checksum mismatch
//   err_tmo    out one-cycle pulse: inter-byte timeout
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 20000,
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    localparam int        LEN_W   = $clog2(MAX_LEN + 1),
    localparam int        TMO_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_empty,
    input  logic [7:0]       r_data,
    output logic             rd_uart,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [LEN_W-1:0] frame_len,
    output logic             err_len,
    output logic             err_chk,
    output logic             err_tmo
);

    localparam int         BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0] MAX_LEN_B = 9'(MAX_LEN);

    state_t            state_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  idx_reg;
    logic [7:0]        chk_reg;
    logic [TMO_W-1:0]  tmo_reg;
    logic [7:0]        m_data_reg;
    logic              m_valid_reg;
    logic              m_last_reg;
    logic              err_len_reg;
    logic              err_chk_reg;
    logic              err_tmo_reg;

    logic              take;
    logic              tmo_hit;
    logic              len_bad;
    logic [LEN_W-1:0]  idx_plus1;
    logic              buf_we;
    logic [BUF_AW-1:0] buf_waddr;
    logic [BUF_AW-1:0] buf_raddr;
    logic [7:0]        buf_rdata;

    // Reading is suspended during SEND so the FIFO absorbs back-pressure.
    // The reset term keeps the strobe low while reset is held.
    assign rd_uart   = rst & ~rx_empty & (state_reg != SEND);
    assign take      = rd_uart;
    assign idx_plus1 = idx_reg + LEN_W'(1);
    assign tmo_hit   = (tmo_reg == TMO_W'(TIMEOUT));
    assign len_bad   = (r_data == 8'd0) || ({1'b0, r_data} > MAX_LEN_B);

    // In CHK the read port points at entry 0 so the first byte can be
    // registered onto m_data together with m_valid. In SEND it looks one
    // ahead so the next byte is ready at each handshake.
    assign buf_we    = take && (state_reg == PAYLOAD);
    assign buf_waddr = idx_reg[BUF_AW-1:0];
    assign buf_raddr = (state_reg == SEND) ? idx_plus1[BUF_AW-1:0] : '0;

    uart_frame_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (r_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= HUNT;
            len_reg     <= '0;
            idx_reg     <= '0;
            chk_reg     <= '0;
            tmo_reg     <= '0;
            m_data_reg  <= '0;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            err_len_reg <= 1'b0;
            err_chk_reg <= 1'b0;
            err_tmo_reg <= 1'b0;
        end else begin
            err_len_reg <= 1'b0;
            err_chk_reg <= 1'b0;
            err_tmo_reg <= 1'b0;

            // Inter-byte timer: cleared by every consumed byte, saturates.
            if (state_reg inside {LEN, PAYLOAD, CHK}) begin
                if (take) begin
                    tmo_reg <= '0;
                end else if (!tmo_hit) begin
                    tmo_reg <= tmo_reg + TMO_W'(1);
                end
            end

            case (state_reg)
                HUNT: begin
                    if (take && (r_data == SOF)) begin
                        state_reg <= LEN;
                        tmo_reg   <= '0;
                    end
                end

                LEN: begin
                    if (take) begin
                        if (len_bad) begin
                            err_len_reg <= 1'b1;
                            state_reg   <= HUNT;
                        end else begin
                            len_reg   <= LEN_W'(r_data);
                            chk_reg   <= r_data;
                            idx_reg   <= '0;
                            state_reg <= PAYLOAD;
                        end
                    end else if (tmo_hit) begin
                        err_tmo_reg <= 1'b1;
                        state_reg   <= HUNT;
                    end
                end

                PAYLOAD: begin
                    if (take) begin
                        chk_reg <= chk_reg ^ r_data;
                        idx_reg <= idx_plus1;
                        if (idx_plus1 == len_reg) begin
                            state_reg <= CHK;
                        end
                    end else if (tmo_hit) begin
                        err_tmo_reg <= 1'b1;
                        state_reg   <= HUNT;
                    end
                end

                CHK: begin
                    if (take) begin
                        if (r_data == chk_reg) begin
                            state_reg   <= SEND;
                            idx_reg     <= '0;
                            m_valid_reg <= 1'b1;
                            m_data_reg  <= buf_rdata;
                            m_last_reg  <= (len_reg == LEN_W'(1));
                        end else begin
                            err_chk_reg <= 1'b1;
                            state_reg   <= HUNT;
                        end
                    end else if (tmo_hit) begin
                        err_tmo_reg <= 1'b1;
                        state_reg   <= HUNT;
                    end
                end

                SEND: begin
                    // m_valid is always high here, so m_ready alone is the handshake.
                    if (m_ready) begin
                        if (m_last_reg) begin
                            m_valid_reg <= 1'b0;
                            m_last_reg  <= 1'b0;
                            idx_reg     <= '0;
                            state_reg   <= HUNT;
                        end else begin
                            idx_reg    <= idx_plus1;
                            m_data_reg <= buf_rdata;
                            m_last_reg <= ((idx_plus1 + LEN_W'(1)) == len_reg);
                        end
                    end
                end

                default: state_reg <= HUNT;
            endcase
        end
    end

    assign m_data    = m_data_reg;
    assign m_valid   = m_valid_reg;
    assign m_last    = m_last_reg;
    assign frame_len = len_reg;
    assign err_len   = err_len_reg;
    assign err_chk   = err_chk_reg;
    assign err_tmo   = err_tmo_reg;

endmodule
